// File: rtl/sha256_pkg.sv
// Shared FSM states and digest geometry for the SHA-256 digest unpacker.
// Used by sha_digest_unpacker and its optional hex-ASCII encoder.
package sha256_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT_TX = 3'd3,
    S_CLEANUP = 3'd4
  } state_t;

  localparam int DIGEST_WORDS     = 8;
  localparam int BYTES_PER_WORD   = 4;
  localparam int DIGEST_BYTES_RAW = 32;
  localparam int DIGEST_BYTES_HEX = 64;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational nibble to lowercase ASCII hex character.
// Only instantiated when the unpacker is built with HEX_ASCII_EN.
module hex_nibble_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = 8'h30;
    unique case (1'b1)
      (nibble < 4'd10): ascii = 8'h30 + {4'h0, nibble};
      default:          ascii = 8'h57 + {4'h0, nibble};
    endcase
  end

endmodule

// File: rtl/sha_digest_unpacker.sv
// Buffers an 8-word SHA-256 digest and streams it MSB-first to uart_tx.
// Define HEX_ASCII_EN to send each byte as two lowercase hex characters.
module sha_digest_unpacker #(
  parameter int DATA_WIDTH    = 32,
  parameter int DIGEST_WORDS  = 8,
  parameter int TIMEOUT_LIMIT = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] core_word_in,
  input  logic                  core_dv_in,
  output logic [7:0]            tx_byte_out,
  output logic                  tx_dv_out,
  input  logic                  tx_done_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  err_out
);

  import sha256_pkg::*;

  localparam int TW = $clog2(TIMEOUT_LIMIT + 1);
  localparam int WI = $clog2(DIGEST_WORDS);
  localparam int RAW_N = DIGEST_WORDS * BYTES_PER_WORD;

`ifdef HEX_ASCII_EN
  localparam logic [6:0] LAST = 7'(2 * RAW_N - 1);
`else
  localparam logic [6:0] LAST = 7'(RAW_N - 1);
`endif

  state_t state, state_n;

  logic [DATA_WIDTH-1:0] words [DIGEST_WORDS];
  logic [3:0]            word_cnt;
  logic [6:0]            byte_cnt;
  logic [TW-1:0]         timer;

  logic                  store;
  logic                  tmo;
  logic [6:0]            idx_n;
  logic [WI-1:0]         wsel;
  logic [1:0]            bsel;
  logic [DATA_WIDTH-1:0] sel_word;
  logic [7:0]            raw_byte;
  logic [7:0]            byte_n;
  logic                  idx_unused;

  assign store = core_dv_in &&
                 (state == S_IDLE || state == S_LOAD);
  assign tmo   = (timer == TW'(TIMEOUT_LIMIT));

  // Index of the byte about to be issued, picked one cycle early
  // so the byte register is valid together with tx_dv_out.
  assign idx_n = (state == S_LOAD) ? 7'd0 : byte_cnt + 7'd1;

`ifdef HEX_ASCII_EN
  logic [3:0] nibble;

  assign wsel       = idx_n[WI+2:3];
  assign bsel       = idx_n[2:1];
  assign nibble     = idx_n[0] ? raw_byte[3:0] : raw_byte[7:4];
  assign idx_unused = ^idx_n[6:WI+3];

  hex_nibble_to_ascii u_hex (
    .nibble (nibble),
    .ascii  (byte_n)
  );
`else
  assign wsel       = idx_n[WI+1:2];
  assign bsel       = idx_n[1:0];
  assign byte_n     = raw_byte;
  assign idx_unused = ^idx_n[6:WI+2];
`endif

  assign sel_word = words[wsel];
  assign raw_byte = sel_word[(DATA_WIDTH-1) - 8*int'(bsel) -: 8];

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (core_dv_in) state_n = S_LOAD;
      end
      S_LOAD: begin
        if (core_dv_in && word_cnt == 4'(DIGEST_WORDS - 1))
          state_n = S_ISSUE;
      end
      S_ISSUE: begin
        state_n = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (tx_done_in)
          state_n = (byte_cnt == LAST) ? S_CLEANUP : S_ISSUE;
        else if (tmo)
          state_n = S_IDLE;
      end
      S_CLEANUP: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      word_cnt    <= '0;
      byte_cnt    <= '0;
      timer       <= '0;
      tx_byte_out <= '0;
      for (int i = 0; i < DIGEST_WORDS; i++)
        words[i] <= '0;
    end else begin
      state <= state_n;
      if (store) begin
        words[word_cnt[WI-1:0]] <= core_word_in;
        word_cnt <= word_cnt + 4'd1;
      end
      if (state == S_LOAD && state_n == S_ISSUE)
        byte_cnt <= '0;
      if (state == S_ISSUE)
        timer <= '0;
      if (state == S_WAIT_TX) begin
        if (tx_done_in) byte_cnt <= byte_cnt + 7'd1;
        else            timer    <= timer + TW'(1);
      end
      if (state_n == S_ISSUE)
        tx_byte_out <= byte_n;
      // Clearing last keeps a timed-out timer from stepping past the limit.
      if (state_n == S_IDLE) begin
        word_cnt <= '0;
        byte_cnt <= '0;
        timer    <= '0;
      end
    end
  end

  assign tx_dv_out = (state == S_ISSUE);
  assign busy_out  = (state != S_IDLE);
  assign done_out  = (state == S_CLEANUP);
  assign err_out   = (state == S_WAIT_TX) && !tx_done_in && tmo;

endmodule

// File: tb/tb_sha_digest_unpacker.sv
// Directed bench for sha_digest_unpacker with a byte scoreboard.
// Honors HEX_ASCII_EN when the design is built with it.
`timescale 1ns/1ps
module tb_sha_digest_unpacker;

`ifdef HEX_ASCII_EN
  localparam int NCH = 64;
`else
  localparam int NCH = 32;
`endif
  localparam int TLIM = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] core_word_in = '0;
  logic        core_dv_in = 1'b0;
  logic        tx_done_in = 1'b0;
  logic [7:0]  tx_byte_out;
  logic        tx_dv_out;
  logic        busy_out;
  logic        done_out;
  logic        err_out;

  sha_digest_unpacker #(
    .DATA_WIDTH    (32),
    .DIGEST_WORDS  (8),
    .TIMEOUT_LIMIT (TLIM)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .core_word_in (core_word_in),
    .core_dv_in   (core_dv_in),
    .tx_byte_out  (tx_byte_out),
    .tx_dv_out    (tx_dv_out),
    .tx_done_in   (tx_done_in),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .err_out      (err_out)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_dv = 0;
  int n_done = 0;
  int n_err = 0;
  int n_ack = 0;
  int err_cyc = 0;
  int last_cyc = 0;
  int first_dv_cyc = 0;
  int ack_delay = 10;
  bit ack_en = 1'b1;

  logic [7:0]  sb [$];
  logic [31:0] abc [8] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };
  logic [31:0] junk [8] = '{
    32'h01234567, 32'h89abcdef, 32'hdeadbeef, 32'hcafef00d,
    32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444
  };

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] asc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + 8'(n);
    return 8'h61 + (8'(n) - 8'd10);
  endfunction

  task automatic push_expected(input logic [31:0] w [8]);
    for (int k = 0; k < 32; k++) begin
      logic [7:0] b;
      b = 8'(w[k/4] >> (24 - 8*(k%4)));
`ifdef HEX_ASCII_EN
      sb.push_back(asc(b[7:4]));
      sb.push_back(asc(b[3:0]));
`else
      sb.push_back(b);
`endif
    end
  endtask

  task automatic send_digest(input logic [31:0] w [8], input int gap);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      core_word_in = w[i];
      core_dv_in = 1'b1;
      last_cyc = cyc;
      @(posedge clk); #1;
      core_dv_in = 1'b0;
      core_word_in = '0;
      if (i < 7)
        repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic check_first_dv(input string tag);
    int lat;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_dv_out === 1'b1) begin
        lat = cyc - last_cyc;
        first_dv_cyc = cyc;
        break;
      end
    end
    check(tag, lat, 1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int i;
    start = n_done;
    i = 0;
    while (n_done == start && i < budget) begin
      @(posedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_done_once"}, n_done - start, 1);
    check({tag, "_idle"}, busy_out, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_byte"}, tx_byte_out, 8'h00);
    check({tag, "_dv"}, tx_dv_out, 1'b0);
    check({tag, "_busy"}, busy_out, 1'b0);
    check({tag, "_done"}, done_out, 1'b0);
    check({tag, "_err"}, err_out, 1'b0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_dv_out === 1'b1) begin
      n_dv++;
      check("sb_has_entry", 32'(sb.size() > 0), 1);
      if (sb.size() > 0)
        check("tx_byte", tx_byte_out, sb.pop_front());
    end
    if (done_out === 1'b1) n_done++;
    if (err_out === 1'b1) begin
      n_err++;
      err_cyc = cyc;
    end
    if (tx_done_in === 1'b1) n_ack++;
  end

  initial forever begin
    @(negedge clk);
    if (tx_dv_out === 1'b1 && ack_en) begin
      repeat (ack_delay) @(posedge clk);
      #1 tx_done_in = 1'b1;
      @(posedge clk);
      #1 tx_done_in = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int e0;
    int c0;
    int a0;
    int i;

    #1 rst_n = 1'b0;
    #11;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back digest words, acks 10 cycles after each pulse.
    d0 = n_dv;
    e0 = n_err;
    push_expected(abc);
    send_digest(abc, 0);
    check_first_dv("t1_latency");
    wait_done("t1", NCH * 14 + 50);
    check("t1_nbytes", n_dv - d0, NCH);
    check("t1_sb_empty", sb.size(), 0);
    check("t1_no_err", n_err - e0, 0);

    // Gapped digest words.
    d0 = n_dv;
    push_expected(abc);
    send_digest(abc, 3);
    check_first_dv("t2_latency");
    wait_done("t2", NCH * 14 + 50);
    check("t2_nbytes", n_dv - d0, NCH);
    check("t2_sb_empty", sb.size(), 0);

    // Core words arriving while bytes are in flight are dropped.
    d0 = n_dv;
    push_expected(abc);
    send_digest(abc, 0);
    i = 0;
    while (n_dv < d0 + 3 && i < 200) begin
      @(posedge clk);
      i++;
    end
    check("t3_reached_byte3", 32'(n_dv >= d0 + 3), 1);
    #1;
    for (int k = 0; k < 8; k++) begin
      core_word_in = junk[k];
      core_dv_in = 1'b1;
      @(posedge clk); #1;
    end
    core_dv_in = 1'b0;
    core_word_in = '0;
    wait_done("t3", NCH * 14 + 50);
    check("t3_nbytes", n_dv - d0, NCH);
    check("t3_sb_empty", sb.size(), 0);

    // TX never acknowledges: abort after the timeout.
    ack_en = 1'b0;
    d0 = n_dv;
    e0 = n_err;
    c0 = n_done;
    push_expected(abc);
    send_digest(abc, 0);
    check_first_dv("t4_latency");
    i = 0;
    while (n_err == e0 && i < 200) begin
      @(posedge clk);
      i++;
    end
    check("t4_err_seen", n_err - e0, 1);
    check("t4_err_delay", err_cyc - first_dv_cyc, TLIM + 1);
    @(negedge clk);
    check("t4_busy_after_err", busy_out, 1'b0);
    check("t4_err_pulse", err_out, 1'b0);
    repeat (3) @(negedge clk);
    check("t4_err_once", n_err - e0, 1);
    check("t4_no_done", n_done - c0, 0);
    check("t4_one_byte", n_dv - d0, 1);
    sb.delete();
    ack_en = 1'b1;
    repeat (5) @(posedge clk);

    // Asynchronous reset after the fifth ack, then a clean digest.
    ack_delay = 10;
    a0 = n_ack;
    e0 = n_err;
    c0 = n_done;
    push_expected(abc);
    send_digest(abc, 0);
    i = 0;
    while (n_ack < a0 + 5 && i < 200) begin
      @(posedge clk);
      i++;
    end
    check("t5_five_acks", n_ack - a0, 5);
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("t5_async_reset");
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    check("t5_no_done", n_done - c0, 0);
    check("t5_no_err", n_err - e0, 0);
    d0 = n_dv;
    push_expected(abc);
    send_digest(abc, 0);
    check_first_dv("t5_latency");
    wait_done("t5", NCH * 14 + 50);
    check("t5_nbytes", n_dv - d0, NCH);
    check("t5_sb_empty", sb.size(), 0);

    // Every ack lands on the cycle the timer hits its limit.
    ack_delay = TLIM + 1;
    d0 = n_dv;
    e0 = n_err;
    push_expected(abc);
    send_digest(abc, 0);
    check_first_dv("t6_latency");
    wait_done("t6", NCH * (TLIM + 6) + 100);
    check("t6_no_err", n_err - e0, 0);
    check("t6_nbytes", n_dv - d0, NCH);
    check("t6_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
